// File: rtl/dw_converter_pkg.sv
// Shared types and width helpers for the stream width converter.
package dw_converter_pkg;

    typedef enum logic {
        EMPTY  = 1'b0,
        SERIAL = 1'b1
    } state_t;

    function automatic int calc_ratio(input int in_dw, input int out_dw);
        return (in_dw > out_dw) ? (in_dw / out_dw) : (out_dw / in_dw);
    endfunction

    function automatic int calc_cnt_w(input int ratio);
        return (ratio > 1) ? $clog2(ratio) : 1;
    endfunction

endpackage

// File: rtl/dw_conv_counter.sv
// Chunk-index counter: clear beats load beats enable; wraps at 2**W.
module dw_conv_counter #(
    parameter int W = 3
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/dw_conv_last_chunk.sv
// Index of the highest strobe group with any bit set; 0 when no strobe is set.
module dw_conv_last_chunk #(
    parameter int RATIO = 8,
    parameter int GW    = 8,
    parameter int CNT_W = 3
) (
    input  logic [RATIO*GW-1:0] strb_i,
    output logic [CNT_W-1:0]    final_k_o
);

    always_comb begin
        final_k_o = '0;
        for (int i = 0; i < RATIO; i++) begin
            if (|strb_i[i*GW +: GW]) begin
                final_k_o = CNT_W'(i);
            end
        end
    end

endmodule

// File: rtl/dw_converter.sv
// Stream width converter: down-size, up-size or pass-through chosen by the widths.
// Down-mode states:  EMPTY | no word buffered   SERIAL | emitting chunks of the buffered word
module dw_converter
    import dw_converter_pkg::*;
#(
    parameter int INPUT_DW  = 512,
    parameter int OUTPUT_DW = 64
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [INPUT_DW-1:0]    data_i,
    input  logic [INPUT_DW/8-1:0]  strb_i,
    input  logic                   last_i,
    input  logic                   valid_i,
    output logic                   ready_o,
    output logic [OUTPUT_DW-1:0]   data_o,
    output logic [OUTPUT_DW/8-1:0] strb_o,
    output logic                   last_o,
    output logic                   valid_o,
    input  logic                   ready_i
);

    localparam int RATIO  = calc_ratio(INPUT_DW, OUTPUT_DW);
    localparam int CNT_W  = calc_cnt_w(RATIO);
    localparam int IN_SW  = INPUT_DW / 8;
    localparam int OUT_SW = OUTPUT_DW / 8;

    if ((INPUT_DW % 8 != 0) || (OUTPUT_DW % 8 != 0) ||
        ((INPUT_DW % OUTPUT_DW != 0) && (OUTPUT_DW % INPUT_DW != 0))) begin : g_bad_width
        $fatal(1, "dw_converter: widths must be byte multiples and integer multiples of each other");
    end

    if (INPUT_DW > OUTPUT_DW) begin : g_down
        state_t               state_q, state_d;
        logic [INPUT_DW-1:0]  buf_data_q, buf_data_d;
        logic [IN_SW-1:0]     buf_strb_q, buf_strb_d;
        logic                 buf_last_q, buf_last_d;
        logic [CNT_W-1:0]     k, final_k;
        logic                 at_final, accept, out_hs;
        logic                 k_load, k_clr, k_en;

        dw_conv_last_chunk #(.RATIO(RATIO), .GW(OUT_SW), .CNT_W(CNT_W)) u_last_chunk (
            .strb_i    (buf_strb_q),
            .final_k_o (final_k)
        );

        dw_conv_counter #(.W(CNT_W)) u_cnt (
            .clk_i      (clk_i),
            .rst_i      (rst_i),
            .clr_i      (k_clr),
            .load_i     (k_load),
            .load_val_i (CNT_W'(0)),
            .en_i       (k_en),
            .cnt_o      (k)
        );

        assign at_final = (k == final_k);

        always_comb begin
            state_d    = state_q;
            buf_data_d = buf_data_q;
            buf_strb_d = buf_strb_q;
            buf_last_d = buf_last_q;
            k_load     = 1'b0;
            k_clr      = 1'b0;
            k_en       = 1'b0;
            ready_o    = 1'b0;
            valid_o    = 1'b0;
            accept     = 1'b0;
            out_hs     = 1'b0;
            case (state_q)
                EMPTY: begin
                    ready_o = 1'b1;
                    accept  = valid_i;
                    if (accept) begin
                        state_d = SERIAL;
                        k_load  = 1'b1;
                    end
                end
                SERIAL: begin
                    valid_o = 1'b1;
                    out_hs  = ready_i;
                    // Refill only as the final chunk leaves, so back-to-back words have no bubble.
                    ready_o = at_final && ready_i;
                    accept  = valid_i && ready_o;
                    if (out_hs) begin
                        if (!at_final) begin
                            k_en = 1'b1;
                        end else if (accept) begin
                            k_load = 1'b1;
                        end else begin
                            k_clr   = 1'b1;
                            state_d = EMPTY;
                        end
                    end
                end
                default: state_d = EMPTY;
            endcase
            if (accept) begin
                buf_data_d = data_i;
                buf_strb_d = strb_i;
                buf_last_d = last_i;
            end
        end

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                state_q    <= EMPTY;
                buf_data_q <= '0;
                buf_strb_q <= '0;
                buf_last_q <= 1'b0;
            end else begin
                state_q    <= state_d;
                buf_data_q <= buf_data_d;
                buf_strb_q <= buf_strb_d;
                buf_last_q <= buf_last_d;
            end
        end

        assign data_o = valid_o ? buf_data_q[OUTPUT_DW*k +: OUTPUT_DW] : '0;
        assign strb_o = valid_o ? buf_strb_q[OUT_SW*k +: OUT_SW] : '0;
        assign last_o = valid_o && buf_last_q && at_final;

    end else begin : g_up
        logic [OUTPUT_DW-1:0] acc_data_q, acc_data_d, out_data_q, out_data_d;
        logic [OUT_SW-1:0]    acc_strb_q, acc_strb_d, out_strb_q, out_strb_d;
        logic                 out_last_q, out_last_d, out_valid_q, out_valid_d;
        logic [OUTPUT_DW-1:0] merged_data;
        logic [OUT_SW-1:0]    merged_strb;
        logic [CNT_W-1:0]     k;
        logic                 accept, complete, k_clr, k_en;

        dw_conv_counter #(.W(CNT_W)) u_cnt (
            .clk_i      (clk_i),
            .rst_i      (rst_i),
            .clr_i      (k_clr),
            .load_i     (1'b0),
            .load_val_i (CNT_W'(0)),
            .en_i       (k_en),
            .cnt_o      (k)
        );

        assign ready_o  = !out_valid_q || ready_i;
        assign accept   = valid_i && ready_o;
        assign complete = (k == CNT_W'(RATIO - 1)) || last_i;

        always_comb begin
            merged_data = acc_data_q;
            merged_strb = acc_strb_q;
            merged_data[INPUT_DW*k +: INPUT_DW] = data_i;
            merged_strb[IN_SW*k +: IN_SW]       = strb_i;
            acc_data_d  = acc_data_q;
            acc_strb_d  = acc_strb_q;
            out_data_d  = out_data_q;
            out_strb_d  = out_strb_q;
            out_last_d  = out_last_q;
            out_valid_d = out_valid_q;
            k_clr       = 1'b0;
            k_en        = 1'b0;
            if (out_valid_q && ready_i) begin
                out_valid_d = 1'b0;
            end
            if (accept) begin
                if (complete) begin
                    // Accumulator is zeroed after each word, so slots above k emit as data 0 / strb 0.
                    out_data_d  = merged_data;
                    out_strb_d  = merged_strb;
                    out_last_d  = last_i;
                    out_valid_d = 1'b1;
                    acc_data_d  = '0;
                    acc_strb_d  = '0;
                    k_clr       = 1'b1;
                end else begin
                    acc_data_d = merged_data;
                    acc_strb_d = merged_strb;
                    k_en       = 1'b1;
                end
            end
        end

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                acc_data_q  <= '0;
                acc_strb_q  <= '0;
                out_data_q  <= '0;
                out_strb_q  <= '0;
                out_last_q  <= 1'b0;
                out_valid_q <= 1'b0;
            end else begin
                acc_data_q  <= acc_data_d;
                acc_strb_q  <= acc_strb_d;
                out_data_q  <= out_data_d;
                out_strb_q  <= out_strb_d;
                out_last_q  <= out_last_d;
                out_valid_q <= out_valid_d;
            end
        end

        assign data_o  = out_data_q;
        assign strb_o  = out_strb_q;
        assign last_o  = out_last_q;
        assign valid_o = out_valid_q;
    end

endmodule

// File: tb/tb_dw_converter.sv
// Directed bench: 512->64 down-sizer and 64->256 up-sizer sharing one clock and reset.
module tb_dw_converter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [511:0] d_data_i;
    logic [63:0]  d_strb_i;
    logic         d_last_i, d_valid_i, d_ready_o;
    logic [63:0]  d_data_o;
    logic [7:0]   d_strb_o;
    logic         d_last_o, d_valid_o, d_ready_i;

    logic [63:0]  u_data_i;
    logic [7:0]   u_strb_i;
    logic         u_last_i, u_valid_i, u_ready_o;
    logic [255:0] u_data_o;
    logic [31:0]  u_strb_o;
    logic         u_last_o, u_valid_o, u_ready_i;

    int n_cmp = 0;
    int n_bad = 0;
    int idx;
    logic [15:0] pat;

    dw_converter #(.INPUT_DW(512), .OUTPUT_DW(64)) u_down (
        .clk_i(clk), .rst_i(rst),
        .data_i(d_data_i), .strb_i(d_strb_i), .last_i(d_last_i),
        .valid_i(d_valid_i), .ready_o(d_ready_o),
        .data_o(d_data_o), .strb_o(d_strb_o), .last_o(d_last_o),
        .valid_o(d_valid_o), .ready_i(d_ready_i)
    );

    dw_converter #(.INPUT_DW(64), .OUTPUT_DW(256)) u_up (
        .clk_i(clk), .rst_i(rst),
        .data_i(u_data_i), .strb_i(u_strb_i), .last_i(u_last_i),
        .valid_i(u_valid_i), .ready_o(u_ready_o),
        .data_o(u_data_o), .strb_o(u_strb_o), .last_o(u_last_o),
        .valid_o(u_valid_o), .ready_i(u_ready_i)
    );

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Chunk i of the word holds base+i.
    function automatic logic [511:0] mk_word(input logic [63:0] base);
        logic [511:0] w;
        for (int i = 0; i < 8; i++) w[64*i +: 64] = base + 64'(i);
        return w;
    endfunction

    task automatic d_send(input logic [511:0] w, input logic [63:0] s, input logic l);
        d_data_i = w; d_strb_i = s; d_last_i = l; d_valid_i = 1'b1;
        @(negedge clk); chk("d_accept_rdy", d_ready_o, 1'b1);
        @(posedge clk); #1; d_valid_i = 1'b0;
    endtask

    task automatic u_send(input logic [63:0] w, input logic [7:0] s, input logic l);
        u_data_i = w; u_strb_i = s; u_last_i = l; u_valid_i = 1'b1;
        @(negedge clk); chk("u_accept_rdy", u_ready_o, 1'b1);
        @(posedge clk); #1; u_valid_i = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        d_data_i = '0; d_strb_i = '0; d_last_i = 1'b0; d_valid_i = 1'b0; d_ready_i = 1'b1;
        u_data_i = '0; u_strb_i = '0; u_last_i = 1'b0; u_valid_i = 1'b0; u_ready_i = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        chk("d_rst_valid", d_valid_o, 1'b0);
        chk("d_rst_ready", d_ready_o, 1'b1);
        chk("d_rst_data", d_data_o, 64'h0);
        chk("d_rst_strb", d_strb_o, 8'h0);
        chk("d_rst_last", d_last_o, 1'b0);
        chk("u_rst_valid", u_valid_o, 1'b0);
        chk("u_rst_ready", u_ready_o, 1'b1);
        chk("u_rst_data", u_data_o, 256'h0);
        @(posedge clk); #1;

        // Full word, all strobes, last
        d_send(mk_word(64'h100), '1, 1'b1);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("t1_valid", d_valid_o, 1'b1);
            chk("t1_data", d_data_o, 64'h100 + 64'(k));
            chk("t1_strb", d_strb_o, 8'hFF);
            chk("t1_last", d_last_o, k == 7);
            chk("t1_ready", d_ready_o, k == 7);
            @(posedge clk); #1;
        end
        @(negedge clk); chk("t1_idle", d_valid_o, 1'b0); @(posedge clk); #1;

        // Only chunks 0 and 1 strobed
        d_send(mk_word(64'h700), 64'h0000_0000_0000_FFFF, 1'b0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("t2_valid", d_valid_o, 1'b1);
            chk("t2_data", d_data_o, 64'h700 + 64'(k));
            chk("t2_strb", d_strb_o, 8'hFF);
            chk("t2_last", d_last_o, 1'b0);
            chk("t2_ready", d_ready_o, k == 1);
            @(posedge clk); #1;
        end
        @(negedge clk); chk("t2_idle", d_valid_o, 1'b0); @(posedge clk); #1;

        // No strobes at all: a single chunk-0 beat
        d_send(mk_word(64'h800), 64'h0, 1'b1);
        @(negedge clk);
        chk("zs_valid", d_valid_o, 1'b1);
        chk("zs_data", d_data_o, 64'h800);
        chk("zs_strb", d_strb_o, 8'h00);
        chk("zs_last", d_last_o, 1'b1);
        chk("zs_ready", d_ready_o, 1'b1);
        @(posedge clk); #1;
        @(negedge clk); chk("zs_idle", d_valid_o, 1'b0); @(posedge clk); #1;

        // Two words back-to-back
        d_data_i = mk_word(64'h200); d_strb_i = '1; d_last_i = 1'b0; d_valid_i = 1'b1;
        @(posedge clk); #1;
        d_data_i = mk_word(64'h300); d_last_i = 1'b1;
        for (int j = 0; j < 16; j++) begin
            @(negedge clk);
            chk("t3_valid", d_valid_o, 1'b1);
            chk("t3_data", d_data_o, (j < 8) ? (64'h200 + 64'(j)) : (64'h300 + 64'(j - 8)));
            chk("t3_last", d_last_o, j == 15);
            @(posedge clk); #1;
            if (j == 7) d_valid_i = 1'b0;
        end
        @(negedge clk); chk("t3_idle", d_valid_o, 1'b0); @(posedge clk); #1;

        // Backpressure on a 5-chunk word
        d_ready_i = 1'b0;
        d_send(mk_word(64'h600), 64'h0000_00FF_FFFF_FFFF, 1'b1);
        idx = 0;
        pat = 16'b1011_0010_0110_1001;
        for (int c = 0; c < 40 && idx < 5; c++) begin
            d_ready_i = pat[c % 16];
            @(negedge clk);
            chk("bp_valid", d_valid_o, 1'b1);
            chk("bp_data", d_data_o, 64'h600 + 64'(idx));
            chk("bp_strb", d_strb_o, 8'hFF);
            chk("bp_last", d_last_o, idx == 4);
            chk("bp_ready", d_ready_o, (idx == 4) && d_ready_i);
            if (d_ready_i) idx++;
            @(posedge clk); #1;
        end
        chk("bp_beats", idx, 5);
        d_ready_i = 1'b1;
        @(negedge clk); chk("bp_idle", d_valid_o, 1'b0); @(posedge clk); #1;

        // Reset while chunk 3 is presented
        d_send(mk_word(64'h400), '1, 1'b1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); chk("t6_pre", d_data_o, 64'h400 + 64'(k));
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(negedge clk); chk("t6_k3", d_data_o, 64'h403);
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        chk("t6_valid", d_valid_o, 1'b0);
        chk("t6_ready", d_ready_o, 1'b1);
        chk("t6_strb", d_strb_o, 8'h00);
        chk("t6_data", d_data_o, 64'h0);
        chk("t6_last", d_last_o, 1'b0);
        @(posedge clk); #1;
        d_send(mk_word(64'h500), '1, 1'b1);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("t6_post_data", d_data_o, 64'h500 + 64'(k));
            chk("t6_post_last", d_last_o, k == 7);
            @(posedge clk); #1;
        end
        @(negedge clk); chk("t6_idle", d_valid_o, 1'b0); @(posedge clk); #1;

        // Up: three beats, last on the third
        u_send(64'hA, 8'hFF, 1'b0);
        @(negedge clk); chk("u4_partial_nv", u_valid_o, 1'b0); @(posedge clk); #1;
        u_send(64'hB, 8'hFF, 1'b0);
        u_send(64'hC, 8'hFF, 1'b1);
        @(negedge clk);
        chk("u4_valid", u_valid_o, 1'b1);
        chk("u4_data", u_data_o, {64'h0, 64'hC, 64'hB, 64'hA});
        chk("u4_strb", u_strb_o, 32'h00FF_FFFF);
        chk("u4_last", u_last_o, 1'b1);
        @(posedge clk); #1;
        @(negedge clk); chk("u4_idle", u_valid_o, 1'b0); @(posedge clk); #1;

        // Up: full word, slot index restarted at 0
        u_send(64'h1, 8'hFF, 1'b0);
        u_send(64'h2, 8'hFF, 1'b0);
        u_send(64'h3, 8'hFF, 1'b0);
        u_send(64'h4, 8'hFF, 1'b0);
        @(negedge clk);
        chk("uf_valid", u_valid_o, 1'b1);
        chk("uf_data", u_data_o, {64'h4, 64'h3, 64'h2, 64'h1});
        chk("uf_strb", u_strb_o, 32'hFFFF_FFFF);
        chk("uf_last", u_last_o, 1'b0);
        @(posedge clk); #1;
        @(negedge clk); chk("uf_idle", u_valid_o, 1'b0); @(posedge clk); #1;

        // Up: stall output, then complete a word while the stalled one drains
        u_ready_i = 1'b0;
        u_send(64'h5, 8'hFF, 1'b0);
        u_send(64'h6, 8'hFF, 1'b0);
        u_send(64'h7, 8'hFF, 1'b0);
        u_send(64'h8, 8'hFF, 1'b0);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("ubp_valid", u_valid_o, 1'b1);
            chk("ubp_data", u_data_o, {64'h8, 64'h7, 64'h6, 64'h5});
            chk("ubp_ready", u_ready_o, 1'b0);
            @(posedge clk); #1;
        end
        u_ready_i = 1'b1;
        u_send(64'hE, 8'h0F, 1'b1);
        @(negedge clk);
        chk("ubp_next_valid", u_valid_o, 1'b1);
        chk("ubp_next_data", u_data_o, {64'h0, 64'h0, 64'h0, 64'hE});
        chk("ubp_next_strb", u_strb_o, 32'h0000_000F);
        chk("ubp_next_last", u_last_o, 1'b1);
        @(posedge clk); #1;
        @(negedge clk); chk("ubp_idle", u_valid_o, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
